// File: rtl/wbvga_modectrl_pkg.sv
// Shared definitions for the VGA mode-control block: register map,
// CTRL bit positions, FSM encoding and the default 640x480 timing.
package wbvga_modectrl_pkg;

    // Word addresses of the register map
    localparam logic [2:0] ADDR_CTRL       = 3'd0;
    localparam logic [2:0] ADDR_BASE       = 3'd1;
    localparam logic [2:0] ADDR_LINEWORDS  = 3'd2;
    localparam logic [2:0] ADDR_HMODE0     = 3'd3;  // {HPORCH, HWIDTH}
    localparam logic [2:0] ADDR_HMODE1     = 3'd4;  // {HRAW, HSYNCH}
    localparam logic [2:0] ADDR_VMODE0     = 3'd5;  // {VPORCH, VHEIGHT}
    localparam logic [2:0] ADDR_VMODE1     = 3'd6;  // {VRAW, VSYNCH}
    localparam logic [2:0] ADDR_FRAMECOUNT = 3'd7;

    // CTRL register bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_COMMIT  = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PENDING = 3;
    localparam int CTRL_ACTIVE  = 4;
    localparam int CTRL_FSTAT   = 5;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Standard 640x480 timing
    localparam int DEF_HWIDTH  = 640;
    localparam int DEF_HPORCH  = 656;
    localparam int DEF_HSYNCH  = 752;
    localparam int DEF_HRAW    = 800;
    localparam int DEF_VHEIGHT = 480;
    localparam int DEF_VPORCH  = 490;
    localparam int DEF_VSYNCH  = 492;
    localparam int DEF_VRAW    = 521;

    // Replace the bytes of cur selected by sel with those of wdata
    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = sel[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/wbvga_moderegs.sv
// Shadow register file for the VGA mode control: byte-select writes and
// the combinational read mux (CTRL and FRAMECOUNT words come from the top).
module wbvga_moderegs
    import wbvga_modectrl_pkg::*;
#(
    parameter int AW      = 24,
    parameter int FW      = 13,
    parameter int LW      = 12,
    parameter int INIT_HW = DEF_HWIDTH,
    parameter int INIT_HP = DEF_HPORCH,
    parameter int INIT_HS = DEF_HSYNCH,
    parameter int INIT_HR = DEF_HRAW,
    parameter int INIT_VH = DEF_VHEIGHT,
    parameter int INIT_VP = DEF_VPORCH,
    parameter int INIT_VS = DEF_VSYNCH,
    parameter int INIT_VR = DEF_VRAW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [2:0]    i_addr,
    input  logic [31:0]   i_data,
    input  logic [3:0]    i_sel,
    input  logic [31:0]   i_ctrl_word,
    input  logic [15:0]   i_framecount,
    output logic [AW-1:0] o_base_addr,
    output logic [FW:0]   o_line_words,
    output logic [FW-1:0] o_hm_width,
    output logic [FW-1:0] o_hm_porch,
    output logic [FW-1:0] o_hm_synch,
    output logic [FW-1:0] o_hm_raw,
    output logic [LW-1:0] o_vm_height,
    output logic [LW-1:0] o_vm_porch,
    output logic [LW-1:0] o_vm_synch,
    output logic [LW-1:0] o_vm_raw,
    output logic [31:0]   o_rdata
);

    logic [31:0] wr_word;
    logic        unused_bits;

    // Read mux; for addresses 1..6 this is also the current word that
    // partial (byte-select) writes merge into
    always_comb begin
        o_rdata = '0;
        case (i_addr)
            ADDR_CTRL:       o_rdata = i_ctrl_word;
            ADDR_BASE:       o_rdata[AW-1:0] = o_base_addr;
            ADDR_LINEWORDS:  o_rdata[FW:0]   = o_line_words;
            ADDR_HMODE0: begin
                o_rdata[FW-1:0]  = o_hm_width;
                o_rdata[16 +: FW] = o_hm_porch;
            end
            ADDR_HMODE1: begin
                o_rdata[FW-1:0]  = o_hm_synch;
                o_rdata[16 +: FW] = o_hm_raw;
            end
            ADDR_VMODE0: begin
                o_rdata[LW-1:0]  = o_vm_height;
                o_rdata[16 +: LW] = o_vm_porch;
            end
            ADDR_VMODE1: begin
                o_rdata[LW-1:0]  = o_vm_synch;
                o_rdata[16 +: LW] = o_vm_raw;
            end
            ADDR_FRAMECOUNT: o_rdata[15:0] = i_framecount;
        endcase
    end

    assign wr_word     = byte_merge(o_rdata, i_data, i_sel);
    assign unused_bits = ^wr_word;

    // Shadow registers: truncated fields, updated only by bus writes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_base_addr  <= '0;
            o_line_words <= '0;
            o_hm_width   <= FW'(INIT_HW);
            o_hm_porch   <= FW'(INIT_HP);
            o_hm_synch   <= FW'(INIT_HS);
            o_hm_raw     <= FW'(INIT_HR);
            o_vm_height  <= LW'(INIT_VH);
            o_vm_porch   <= LW'(INIT_VP);
            o_vm_synch   <= LW'(INIT_VS);
            o_vm_raw     <= LW'(INIT_VR);
        end else if (i_wr) begin
            case (i_addr)
                ADDR_BASE:      o_base_addr  <= wr_word[AW-1:0];
                ADDR_LINEWORDS: o_line_words <= wr_word[FW:0];
                ADDR_HMODE0: begin
                    o_hm_width <= wr_word[FW-1:0];
                    o_hm_porch <= wr_word[16 +: FW];
                end
                ADDR_HMODE1: begin
                    o_hm_synch <= wr_word[FW-1:0];
                    o_hm_raw   <= wr_word[16 +: FW];
                end
                ADDR_VMODE0: begin
                    o_vm_height <= wr_word[LW-1:0];
                    o_vm_porch  <= wr_word[16 +: LW];
                end
                ADDR_VMODE1: begin
                    o_vm_synch <= wr_word[LW-1:0];
                    o_vm_raw   <= wr_word[16 +: LW];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wbvga_modectrl.sv
// VGA mode control: Wishbone slave holding shadow mode registers and
// driving the active configuration, which only changes at frame
// boundaries or while the reader is off. Also counts frames and raises
// a maskable sticky frame interrupt.
module wbvga_modectrl
    import wbvga_modectrl_pkg::*;
#(
    parameter int AW      = 24,
    parameter int FW      = 13,
    parameter int LW      = 12,
    parameter int INIT_HW = DEF_HWIDTH,
    parameter int INIT_HP = DEF_HPORCH,
    parameter int INIT_HS = DEF_HSYNCH,
    parameter int INIT_HR = DEF_HRAW,
    parameter int INIT_VH = DEF_VHEIGHT,
    parameter int INIT_VP = DEF_VPORCH,
    parameter int INIT_VS = DEF_VSYNCH,
    parameter int INIT_VR = DEF_VRAW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [2:0]    i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic [3:0]    i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic [31:0]   o_wb_data,
    input  logic          i_frame,
    output logic          o_en,
    output logic [AW-1:0] o_base_addr,
    output logic [FW:0]   o_line_words,
    output logic [FW-1:0] o_hm_width,
    output logic [FW-1:0] o_hm_porch,
    output logic [FW-1:0] o_hm_synch,
    output logic [FW-1:0] o_hm_raw,
    output logic [LW-1:0] o_vm_height,
    output logic [LW-1:0] o_vm_porch,
    output logic [LW-1:0] o_vm_synch,
    output logic [LW-1:0] o_vm_raw,
    output logic          o_interrupt
);

    state_t        state, state_nx;
    logic          load_active;
    logic          en_req, ie, commit_q, fstat;
    logic [15:0]   framecount;
    logic          wb_req, wb_wr, ctrl_wr, fstat_clr;
    logic [31:0]   ctrl_word, rdata;

    logic [AW-1:0] sh_base;
    logic [FW:0]   sh_line_words;
    logic [FW-1:0] sh_hw, sh_hp, sh_hs, sh_hr;
    logic [LW-1:0] sh_vh, sh_vp, sh_vs, sh_vr;

    assign wb_req     = i_wb_cyc & i_wb_stb;
    assign wb_wr      = wb_req & i_wb_we;
    assign ctrl_wr    = wb_wr && (i_wb_addr == ADDR_CTRL) && i_wb_sel[0];
    assign fstat_clr  = ctrl_wr && i_wb_data[CTRL_FSTAT];
    assign o_wb_stall = 1'b0;
    assign o_en       = (state != ST_OFF);

    // CTRL readback word
    always_comb begin
        ctrl_word               = '0;
        ctrl_word[CTRL_EN]      = en_req;
        ctrl_word[CTRL_IE]      = ie;
        ctrl_word[CTRL_PENDING] = (state == ST_PEND);
        ctrl_word[CTRL_ACTIVE]  = o_en;
        ctrl_word[CTRL_FSTAT]   = fstat;
    end

    wbvga_moderegs #(
        .AW(AW), .FW(FW), .LW(LW),
        .INIT_HW(INIT_HW), .INIT_HP(INIT_HP), .INIT_HS(INIT_HS), .INIT_HR(INIT_HR),
        .INIT_VH(INIT_VH), .INIT_VP(INIT_VP), .INIT_VS(INIT_VS), .INIT_VR(INIT_VR)
    ) u_regs (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_wr         (wb_wr),
        .i_addr       (i_wb_addr),
        .i_data       (i_wb_data),
        .i_sel        (i_wb_sel),
        .i_ctrl_word  (ctrl_word),
        .i_framecount (framecount),
        .o_base_addr  (sh_base),
        .o_line_words (sh_line_words),
        .o_hm_width   (sh_hw),
        .o_hm_porch   (sh_hp),
        .o_hm_synch   (sh_hs),
        .o_hm_raw     (sh_hr),
        .o_vm_height  (sh_vh),
        .o_vm_porch   (sh_vp),
        .o_vm_synch   (sh_vs),
        .o_vm_raw     (sh_vr),
        .o_rdata      (rdata)
    );

    // Bus response: single-cycle ack with registered read data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= wb_req;
            if (wb_req)
                o_wb_data <= rdata;
        end
    end

    // CTRL bits; COMMIT is a one-cycle pulse seen by the FSM a cycle later
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            en_req   <= 1'b0;
            ie       <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            commit_q <= ctrl_wr && i_wb_data[CTRL_COMMIT];
            if (ctrl_wr) begin
                en_req <= i_wb_data[CTRL_EN];
                ie     <= i_wb_data[CTRL_IE];
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= ST_OFF;
        else
            state <= state_nx;
    end

    // Next state and active-copy strobe; disable overrides any pending commit
    always_comb begin
        state_nx    = state;
        load_active = 1'b0;
        case (state)
            ST_OFF: begin
                if (en_req) begin
                    state_nx    = ST_RUN;
                    load_active = 1'b1;
                end else if (commit_q) begin
                    load_active = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en_req)
                    state_nx = ST_OFF;
                else if (commit_q)
                    state_nx = ST_PEND;
            end
            ST_PEND: begin
                if (!en_req) begin
                    state_nx = ST_OFF;
                end else if (i_frame) begin
                    state_nx    = ST_RUN;
                    load_active = 1'b1;
                end
            end
            default: state_nx = ST_OFF;
        endcase
    end

    // Active configuration: copy of the shadow registers taken on load_active
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_base_addr  <= '0;
            o_line_words <= '0;
            o_hm_width   <= FW'(INIT_HW);
            o_hm_porch   <= FW'(INIT_HP);
            o_hm_synch   <= FW'(INIT_HS);
            o_hm_raw     <= FW'(INIT_HR);
            o_vm_height  <= LW'(INIT_VH);
            o_vm_porch   <= LW'(INIT_VP);
            o_vm_synch   <= LW'(INIT_VS);
            o_vm_raw     <= LW'(INIT_VR);
        end else if (load_active) begin
            o_base_addr  <= sh_base;
            o_line_words <= sh_line_words;
            o_hm_width   <= sh_hw;
            o_hm_porch   <= sh_hp;
            o_hm_synch   <= sh_hs;
            o_hm_raw     <= sh_hr;
            o_vm_height  <= sh_vh;
            o_vm_porch   <= sh_vp;
            o_vm_synch   <= sh_vs;
            o_vm_raw     <= sh_vr;
        end
    end

    // Frame counter, sticky frame status (set beats clear) and interrupt
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            framecount  <= '0;
            fstat       <= 1'b0;
            o_interrupt <= 1'b0;
        end else begin
            if (o_en && i_frame) begin
                framecount <= framecount + 16'd1;
                fstat      <= 1'b1;
            end else if (fstat_clr) begin
                fstat <= 1'b0;
            end
            o_interrupt <= fstat & ie;
        end
    end

endmodule

// File: tb/tb_wbvga_modectrl.sv
// Directed bench for wbvga_modectrl: bus access, enable sequencing,
// frame-synchronous commits, frame counter and interrupt.
module tb_wbvga_modectrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        stall, ack;
    logic [31:0] rdata;
    logic        frame;
    logic        en;
    logic [23:0] base;
    logic [13:0] lwords;
    logic [12:0] hw, hp, hs, hr;
    logic [11:0] vh, vp, vs, vr;
    logic        irq;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    wbvga_modectrl dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_wb_cyc     (cyc),
        .i_wb_stb     (stb),
        .i_wb_we      (we),
        .i_wb_addr    (addr),
        .i_wb_data    (wdata),
        .i_wb_sel     (sel),
        .o_wb_stall   (stall),
        .o_wb_ack     (ack),
        .o_wb_data    (rdata),
        .i_frame      (frame),
        .o_en         (en),
        .o_base_addr  (base),
        .o_line_words (lwords),
        .o_hm_width   (hw),
        .o_hm_porch   (hp),
        .o_hm_synch   (hs),
        .o_hm_raw     (hr),
        .o_vm_height  (vh),
        .o_vm_porch   (vp),
        .o_vm_synch   (vs),
        .o_vm_raw     (vr),
        .o_interrupt  (irq)
    );

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
        tick(1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
        tick(1);
        cyc = 1'b0; stb = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick(1);
        frame = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++; if (ack !== 1'b0) $display("FAIL rst_ack got %b want 0", ack); else passes++;
        checks++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else passes++;
        wb_read(3'd3, d);
        checks++; if (d !== 32'h0290_0280) $display("FAIL rst_hmode0 got %h want 02900280", d); else passes++;
        checks++; if (ack !== 1'b1) $display("FAIL rd_ack got %b want 1", ack); else passes++;
        wb_read(3'd4, d);
        checks++; if (d !== 32'h0320_02F0) $display("FAIL rst_hmode1 got %h want 032002f0", d); else passes++;
        wb_read(3'd5, d);
        checks++; if (d !== 32'h01EA_01E0) $display("FAIL rst_vmode0 got %h want 01ea01e0", d); else passes++;
        wb_read(3'd6, d);
        checks++; if (d !== 32'h0209_01EC) $display("FAIL rst_vmode1 got %h want 020901ec", d); else passes++;
        checks++; if (en !== 1'b0) $display("FAIL rst_en got %b want 0", en); else passes++;
        checks++; if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq); else passes++;
        checks++; if (hw !== 13'd640) $display("FAIL rst_hw got %0d want 640", hw); else passes++;
        checks++; if (vr !== 12'd521) $display("FAIL rst_vr got %0d want 521", vr); else passes++;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h0) $display("FAIL rst_ctrl got %h want 0", d); else passes++;
    endtask

    task automatic test_off_commit();
        logic [31:0] d;
        wb_write(3'd1, 32'h0000_2345, 4'hF);
        wb_write(3'd0, 32'h0000_0002, 4'hF);
        tick(1);
        checks++; if (base !== 24'h002345) $display("FAIL off_commit_base got %h want 002345", base); else passes++;
        checks++; if (en !== 1'b0) $display("FAIL off_commit_en got %b want 0", en); else passes++;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h0) $display("FAIL off_commit_ctrl got %h want 0", d); else passes++;
    endtask

    task automatic test_enable();
        logic [31:0] d;
        wb_write(3'd1, 32'h0000_1000, 4'hF);
        wb_write(3'd2, 32'd160, 4'hF);
        wb_write(3'd0, 32'h0000_0005, 4'hF);
        checks++; if (ack !== 1'b1) $display("FAIL en_ack got %b want 1", ack); else passes++;
        checks++; if (en !== 1'b0) $display("FAIL en_in_ack got %b want 0", en); else passes++;
        tick(1);
        checks++; if (en !== 1'b1) $display("FAIL en_after_ack got %b want 1", en); else passes++;
        checks++; if (ack !== 1'b0) $display("FAIL ack_drop got %b want 0", ack); else passes++;
        checks++; if (base !== 24'h001000) $display("FAIL en_base got %h want 001000", base); else passes++;
        checks++; if (lwords !== 14'd160) $display("FAIL en_lwords got %0d want 160", lwords); else passes++;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h15) $display("FAIL en_ctrl got %h want 15", d); else passes++;
    endtask

    task automatic test_commit_pend();
        logic [31:0] d;
        wb_write(3'd3, 32'h0290_0320, 4'hF);
        wb_write(3'd0, 32'h0000_0007, 4'hF);
        tick(1);
        wb_read(3'd0, d);
        checks++; if (d !== 32'h1D) $display("FAIL pend_ctrl got %h want 1d", d); else passes++;
        tick(3);
        checks++; if (hw !== 13'd640) $display("FAIL pend_hw_hold got %0d want 640", hw); else passes++;
        pulse_frame();
        checks++; if (hw !== 13'd800) $display("FAIL frame_hw got %0d want 800", hw); else passes++;
        checks++; if (hp !== 13'd656) $display("FAIL frame_hp got %0d want 656", hp); else passes++;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h35) $display("FAIL after_frame_ctrl got %h want 35", d); else passes++;
    endtask

    task automatic test_commit_with_frame();
        logic [31:0] d;
        wb_write(3'd5, 32'h01EA_0258, 4'hF);
        frame = 1'b1;
        wb_write(3'd0, 32'h0000_0007, 4'hF);
        frame = 1'b0;
        tick(1);
        checks++; if (vh !== 12'd480) $display("FAIL cwf_vh_hold got %0d want 480", vh); else passes++;
        frame = 1'b1;
        wb_write(3'd3, 32'h0000_0400, 4'b0011);
        frame = 1'b0;
        checks++; if (vh !== 12'd600) $display("FAIL cwf_vh got %0d want 600", vh); else passes++;
        checks++; if (hw !== 13'd800) $display("FAIL copy_old_shadow got %0d want 800", hw); else passes++;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h35) $display("FAIL cwf_ctrl got %h want 35", d); else passes++;
        wb_write(3'd0, 32'h0000_0007, 4'hF);
        tick(1);
        pulse_frame();
        checks++; if (hw !== 13'd1024) $display("FAIL held_shadow_hw got %0d want 1024", hw); else passes++;
        checks++; if (hp !== 13'd656) $display("FAIL bytesel_hp got %0d want 656", hp); else passes++;
    endtask

    task automatic test_frames_irq();
        logic [31:0] d;
        do_reset();
        wb_write(3'd0, 32'h0000_0005, 4'hF);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            pulse_frame();
            tick(1);
        end
        wb_read(3'd7, d);
        checks++; if (d !== 32'd3) $display("FAIL fcount got %0d want 3", d); else passes++;
        checks++; if (irq !== 1'b1) $display("FAIL irq_set got %b want 1", irq); else passes++;
        wb_write(3'd0, 32'h0000_0025, 4'hF);
        tick(1);
        checks++; if (irq !== 1'b0) $display("FAIL irq_clr got %b want 0", irq); else passes++;
        frame = 1'b1;
        wb_write(3'd0, 32'h0000_0025, 4'hF);
        frame = 1'b0;
        tick(1);
        checks++; if (irq !== 1'b1) $display("FAIL set_beats_clr got %b want 1", irq); else passes++;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h35) $display("FAIL irq_ctrl got %h want 35", d); else passes++;
        wb_write(3'd0, 32'h0000_0001, 4'hF);
        tick(1);
        checks++; if (irq !== 1'b0) $display("FAIL irq_mask got %b want 0", irq); else passes++;
    endtask

    task automatic test_disable_in_pend();
        logic [31:0] d;
        wb_write(3'd6, 32'h0000_01F4, 4'b0011);
        wb_write(3'd0, 32'h0000_0003, 4'hF);
        tick(1);
        wb_read(3'd0, d);
        checks++; if (d !== 32'h39) $display("FAIL dis_pend_ctrl got %h want 39", d); else passes++;
        wb_write(3'd0, 32'h0000_0000, 4'hF);
        tick(1);
        checks++; if (en !== 1'b0) $display("FAIL dis_en got %b want 0", en); else passes++;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h20) $display("FAIL dis_ctrl got %h want 20", d); else passes++;
        pulse_frame();
        tick(1);
        checks++; if (vs !== 12'd492) $display("FAIL dis_vs got %0d want 492", vs); else passes++;
        wb_read(3'd7, d);
        checks++; if (d !== 32'd4) $display("FAIL dis_fcount got %0d want 4", d); else passes++;
    endtask

    task automatic test_reset_in_pend();
        logic [31:0] d;
        wb_write(3'd3, 32'h0000_0100, 4'b0011);
        wb_write(3'd0, 32'h0000_0003, 4'hF);
        tick(2);
        checks++; if (hw !== 13'd256) $display("FAIL reen_hw got %0d want 256", hw); else passes++;
        wb_write(3'd3, 32'h0000_0200, 4'b0011);
        wb_write(3'd0, 32'h0000_0003, 4'hF);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        wb_read(3'd0, d);
        checks++; if (d !== 32'h0) $display("FAIL rip_ctrl got %h want 0", d); else passes++;
        pulse_frame();
        tick(1);
        checks++; if (hw !== 13'd640) $display("FAIL rip_hw got %0d want 640", hw); else passes++;
        checks++; if (en !== 1'b0) $display("FAIL rip_en got %b want 0", en); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0; frame = 1'b0;
        test_reset();
        test_off_commit();
        test_enable();
        test_commit_pend();
        test_commit_with_frame();
        test_frames_irq();
        test_disable_in_pend();
        test_reset_in_pend();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
